// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer with retire counting and memory timeout halt.
// Optional SEQ_TRACE_EN: simulation-only retire/halt trace messages.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_branch,
  input  logic             dec_uncond,
  input  logic             dec_halt,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_take,
  output logic             reg_write_en,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] next_state;
  logic       ctl_mem_read;
  logic       ctl_mem_write;
  logic       ctl_reg_write;
  logic       ctl_branch;
  logic       ctl_uncond;
  logic       ctl_take;
  logic [7:0] wait_cnt;
  logic       exec_take;
  logic       mem_timeout;
  logic       retire_dest_idle;

  // EXECUTE resolves the branch from the live ALU flag; later states use the latched copy.
  assign exec_take        = ctl_uncond | (ctl_branch & alu_zero);
  assign mem_timeout      = (state == S_MEMORY) && !mem_ready && (wait_cnt == WAIT_LAST);
  assign retire_dest_idle = halt_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   next_state = S_DECODE;
      S_DECODE:  next_state = dec_halt ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (ctl_mem_read || ctl_mem_write) next_state = S_MEMORY;
        else if (ctl_reg_write)            next_state = S_WRITEBACK;
        else                               next_state = retire_dest_idle ? S_IDLE : S_FETCH;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (ctl_mem_read) next_state = S_WRITEBACK;
          else              next_state = retire_dest_idle ? S_IDLE : S_FETCH;
        end else if (mem_timeout) begin
          next_state = S_HALT;
        end
      end
      S_WRITEBACK: next_state = retire_dest_idle ? S_IDLE : S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_take      = 1'b0;
    reg_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    busy         = (state >= S_FETCH) && (state <= S_WRITEBACK);
    halted       = (state == S_HALT);
    case (state)
      S_FETCH: ir_write = 1'b1;
      S_EXECUTE: begin
        if (!ctl_mem_read && !ctl_mem_write && !ctl_reg_write) begin
          pc_write = 1'b1;
          pc_take  = exec_take;
        end
      end
      S_MEMORY: begin
        // Reads win when the decoder flags both directions.
        mem_read_en  = ctl_mem_read;
        mem_write_en = ctl_mem_write & ~ctl_mem_read;
        if (mem_ready && !ctl_mem_read) begin
          pc_write = 1'b1;
          pc_take  = ctl_take;
        end
      end
      S_WRITEBACK: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        pc_take      = ctl_take;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctl_mem_read  <= 1'b0;
      ctl_mem_write <= 1'b0;
      ctl_reg_write <= 1'b0;
      ctl_branch    <= 1'b0;
      ctl_uncond    <= 1'b0;
      ctl_take      <= 1'b0;
      wait_cnt      <= 8'd0;
      mem_error     <= 1'b0;
      instr_count   <= '0;
    end else begin
      if (state == S_DECODE) begin
        ctl_mem_read  <= dec_mem_read;
        ctl_mem_write <= dec_mem_write;
        ctl_reg_write <= dec_reg_write;
        ctl_branch    <= dec_branch;
        ctl_uncond    <= dec_uncond;
        ctl_take      <= 1'b0;
      end
      if (state == S_EXECUTE) begin
        ctl_take <= exec_take;
        wait_cnt <= 8'd0;
      end
      if (state == S_MEMORY && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (mem_timeout) begin
        mem_error <= 1'b1;
      end
      if (pc_write) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (pc_write) begin
        $display("RETIRE %0d take=%0d", instr_count + CNT_W'(1), pc_take);
      end
      if (next_state == S_HALT && state != S_HALT) begin
        $display("HALT err=%0d", mem_error | mem_timeout);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (default MEM_TIMEOUT=15, CNT_W=32).
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, halt_req;
  logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_branch, dec_uncond, dec_halt;
  logic        alu_zero, mem_ready;
  logic        ir_write, pc_write, pc_take, reg_write_en, mem_read_en, mem_write_en;
  logic [2:0]  state;
  logic        busy, halted, mem_error;
  logic [31:0] instr_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  multicycle_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
    .dec_branch(dec_branch), .dec_uncond(dec_uncond), .dec_halt(dec_halt),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_take(pc_take), .reg_write_en(reg_write_en),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .state(state),
    .busy(busy), .halted(halted), .mem_error(mem_error), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic set_dec(input logic mr, input logic mw, input logic rw,
                         input logic br, input logic un, input logic ht);
    dec_mem_read = mr; dec_mem_write = mw; dec_reg_write = rw;
    dec_branch = br; dec_uncond = un; dec_halt = ht;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
  endtask

  // Returns in cycle 1 (FETCH) of the first instruction.
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk_cnt++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else pass_cnt++;
    chk_cnt++; if ({ir_write, pc_write, pc_take, reg_write_en, mem_read_en, mem_write_en} !== 6'b0)
      $display("FAIL reset_strobes: got %b expected 000000",
               {ir_write, pc_write, pc_take, reg_write_en, mem_read_en, mem_write_en}); else pass_cnt++;
    chk_cnt++; if ({busy, halted, mem_error} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {busy, halted, mem_error}); else pass_cnt++;
    chk_cnt++; if (instr_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", instr_count); else pass_cnt++;
    cyc();
    chk_cnt++; if (state !== 3'd0) $display("FAIL idle_hold: got %0d expected 0", state); else pass_cnt++;
  endtask

  task automatic test_add();
    do_reset();
    set_dec(0, 0, 1, 0, 0, 0);
    mem_ready = 1'b1;
    pulse_start();
    chk_cnt++; if ({state, ir_write, busy} !== {3'd1, 1'b1, 1'b1})
      $display("FAIL add_fetch: got state=%0d ir=%b busy=%b expected 1 1 1", state, ir_write, busy); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, ir_write} !== {3'd2, 1'b0})
      $display("FAIL add_decode: got state=%0d ir=%b expected 2 0", state, ir_write); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, pc_write, mem_read_en, mem_write_en} !== {3'd3, 3'b000})
      $display("FAIL add_execute: got state=%0d pcw=%b expected 3 0", state, pc_write); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, reg_write_en, pc_write, pc_take} !== {3'd5, 3'b110})
      $display("FAIL add_wb: got state=%0d rw/pcw/take=%b expected 5 110", state, {reg_write_en, pc_write, pc_take}); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, instr_count} !== {3'd1, 32'd1})
      $display("FAIL add_retire: got state=%0d count=%0d expected 1 1", state, instr_count); else pass_cnt++;
    mem_ready = 1'b0;
  endtask

  task automatic test_ldur();
    int rd = 0;
    int wr = 0;
    do_reset();
    set_dec(1, 0, 1, 0, 0, 0);
    pulse_start();
    cyc(); cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      if (state == 3'd4 && mem_read_en) rd++;
      if (mem_write_en || pc_write) wr++;
      cyc();
    end
    mem_ready = 1'b0;
    chk_cnt++; if (rd != 3) $display("FAIL ldur_read_cycles: got %0d expected 3", rd); else pass_cnt++;
    chk_cnt++; if (wr != 0) $display("FAIL ldur_no_write_or_retire: got %0d expected 0", wr); else pass_cnt++;
    chk_cnt++; if ({state, reg_write_en, pc_write, instr_count} !== {3'd5, 2'b11, 32'd0})
      $display("FAIL ldur_wb: got state=%0d rw=%b pcw=%b count=%0d expected 5 1 1 0",
               state, reg_write_en, pc_write, instr_count); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, instr_count} !== {3'd1, 32'd1})
      $display("FAIL ldur_retire: got state=%0d count=%0d expected 1 1", state, instr_count); else pass_cnt++;
  endtask

  task automatic test_cbz();
    do_reset();
    set_dec(0, 0, 0, 1, 0, 0);
    pulse_start();
    cyc(); cyc();
    alu_zero = 1'b1;
    #1;
    chk_cnt++; if ({state, pc_write, pc_take} !== {3'd3, 2'b11})
      $display("FAIL cbz_taken: got state=%0d pcw/take=%b expected 3 11", state, {pc_write, pc_take}); else pass_cnt++;
    cyc();
    alu_zero = 1'b0;
    chk_cnt++; if ({state, instr_count} !== {3'd1, 32'd1})
      $display("FAIL cbz_taken_retire: got state=%0d count=%0d expected 1 1", state, instr_count); else pass_cnt++;
    cyc(); cyc();
    #1;
    chk_cnt++; if ({state, pc_write, pc_take} !== {3'd3, 2'b10})
      $display("FAIL cbz_not_taken: got state=%0d pcw/take=%b expected 3 10", state, {pc_write, pc_take}); else pass_cnt++;
    cyc();
    chk_cnt++; if (instr_count !== 32'd2) $display("FAIL cbz_count: got %0d expected 2", instr_count); else pass_cnt++;
  endtask

  task automatic test_uncond_wb();
    do_reset();
    set_dec(0, 0, 1, 0, 1, 0);
    pulse_start();
    cyc(); cyc();
    alu_zero = 1'b0;
    cyc();
    alu_zero = 1'b0;
    #1;
    chk_cnt++; if ({state, pc_write, pc_take} !== {3'd5, 2'b11})
      $display("FAIL uncond_wb_take: got state=%0d pcw/take=%b expected 5 11", state, {pc_write, pc_take}); else pass_cnt++;
  endtask

  task automatic test_read_priority();
    do_reset();
    set_dec(1, 1, 1, 0, 0, 0);
    pulse_start();
    cyc(); cyc(); cyc();
    #1;
    chk_cnt++; if ({state, mem_read_en, mem_write_en} !== {3'd4, 2'b10})
      $display("FAIL both_priority: got state=%0d rd/wr=%b expected 4 10", state, {mem_read_en, mem_write_en}); else pass_cnt++;
    mem_ready = 1'b1;
    #1;
    chk_cnt++; if (pc_write !== 1'b0) $display("FAIL both_no_mem_retire: got %b expected 0", pc_write); else pass_cnt++;
    cyc();
    mem_ready = 1'b0;
    chk_cnt++; if (state !== 3'd5) $display("FAIL both_to_wb: got %0d expected 5", state); else pass_cnt++;
  endtask

  task automatic test_stur_timeout();
    int wr = 0;
    int rd = 0;
    do_reset();
    set_dec(0, 1, 0, 0, 0, 0);
    pulse_start();
    cyc(); cyc(); cyc();
    for (int i = 0; i < 40 && state == 3'd4; i++) begin
      #1;
      if (mem_write_en) wr++;
      if (mem_read_en || pc_write) rd++;
      cyc();
    end
    chk_cnt++; if (wr != 15) $display("FAIL stur_write_cycles: got %0d expected 15", wr); else pass_cnt++;
    chk_cnt++; if (rd != 0) $display("FAIL stur_stray_strobes: got %0d expected 0", rd); else pass_cnt++;
    chk_cnt++; if ({state, halted, busy, mem_error} !== {3'd6, 3'b101})
      $display("FAIL stur_halt: got state=%0d halted=%b busy=%b err=%b expected 6 1 0 1",
               state, halted, busy, mem_error); else pass_cnt++;
    chk_cnt++; if (instr_count !== 32'd0) $display("FAIL stur_count: got %0d expected 0", instr_count); else pass_cnt++;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk_cnt++; if ({state, mem_error} !== {3'd6, 1'b1})
      $display("FAIL halt_ignores_start: got state=%0d err=%b expected 6 1", state, mem_error); else pass_cnt++;
  endtask

  task automatic test_halt_req();
    do_reset();
    set_dec(0, 0, 1, 0, 0, 0);
    pulse_start();
    cyc(); cyc(); cyc();
    cyc();
    chk_cnt++; if ({state, instr_count} !== {3'd1, 32'd1})
      $display("FAIL hreq_first: got state=%0d count=%0d expected 1 1", state, instr_count); else pass_cnt++;
    cyc();
    halt_req = 1'b1;
    cyc();
    chk_cnt++; if (state !== 3'd3) $display("FAIL hreq_exec: got %0d expected 3", state); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, pc_write} !== {3'd5, 1'b1})
      $display("FAIL hreq_wb: got state=%0d pcw=%b expected 5 1", state, pc_write); else pass_cnt++;
    cyc();
    halt_req = 1'b0;
    chk_cnt++; if ({state, busy, instr_count} !== {3'd0, 1'b0, 32'd2})
      $display("FAIL hreq_idle: got state=%0d busy=%b count=%0d expected 0 0 2", state, busy, instr_count); else pass_cnt++;
    cyc();
    chk_cnt++; if (state !== 3'd0) $display("FAIL hreq_stay_idle: got %0d expected 0", state); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_dec(0, 0, 1, 0, 0, 0);
    pulse_start();
    cyc(); cyc(); cyc();
    cyc();
    set_dec(1, 0, 1, 0, 0, 0);
    cyc(); cyc(); cyc();
    chk_cnt++; if ({state, instr_count} !== {3'd4, 32'd1})
      $display("FAIL rmid_in_memory: got state=%0d count=%0d expected 4 1", state, instr_count); else pass_cnt++;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk_cnt++; if ({state, instr_count, mem_error, busy} !== {3'd0, 32'd0, 2'b00})
      $display("FAIL rmid_state: got state=%0d count=%0d err=%b busy=%b expected 0 0 0 0",
               state, instr_count, mem_error, busy); else pass_cnt++;
    chk_cnt++; if ({ir_write, pc_write, pc_take, reg_write_en, mem_read_en, mem_write_en} !== 6'b0)
      $display("FAIL rmid_strobes: got %b expected 000000",
               {ir_write, pc_write, pc_take, reg_write_en, mem_read_en, mem_write_en}); else pass_cnt++;
  endtask

  task automatic test_dec_halt();
    do_reset();
    set_dec(0, 0, 0, 0, 0, 1);
    pulse_start();
    cyc();
    #1;
    chk_cnt++; if (pc_write !== 1'b0) $display("FAIL dhalt_no_retire: got %b expected 0", pc_write); else pass_cnt++;
    cyc();
    chk_cnt++; if ({state, halted, mem_error, instr_count} !== {3'd6, 2'b10, 32'd0})
      $display("FAIL dhalt_state: got state=%0d halted=%b err=%b count=%0d expected 6 1 0 0",
               state, halted, mem_error, instr_count); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_ldur();
    test_cbz();
    test_uncond_wb();
    test_read_priority();
    test_stur_timeout();
    test_halt_req();
    test_reset_mid();
    test_dec_halt();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control sequencer for the ARM-subset processor datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK instead of completing it in one cycle. It generates the write-enables for the PC unit, the instruction register, the register file (Operand_Prep) and the data cache. It handles the cache's ready handshake, halting and retired-instruction counting.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEMORY waiting for mem_ready before an error halt (legal range 1..255).
CNT_W, 32, width of instr_count.

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  leave IDLE and begin fetching
halt_req  input  1  stop at the next instruction boundary
dec_mem_read  input  1  MemRead from Decoder_Controller
dec_mem_write  input  1  MemWrite from Decoder_Controller
dec_reg_write  input  1  RegWrite from Decoder_Controller
dec_branch  input  1  Branch (conditional) from Decoder_Controller
dec_uncond  input  1  Uncondbranch from Decoder_Controller
dec_halt  input  1  decoded HALT opcode
alu_zero  input  1  Zero flag from the ALU
mem_ready  input  1  data cache access complete
ir_write  output  1  load the instruction register
pc_write  output  1  update the PC (instruction retire)
pc_take  output  1  PC source select: 1 = branch target, 0 = PC+4; valid while pc_write=1
reg_write_en  output  1  register file write strobe
mem_read_en  output  1  data cache read request
mem_write_en  output  1  data cache write request
state  output  3  current state encoding
busy  output  1  1 in any state except IDLE and HALT
halted  output  1  1 in HALT
mem_error  output  1  sticky; set on MEMORY timeout
instr_count  output  CNT_W  number of retired instructions

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Encoding 7 is illegal and goes to IDLE on the next edge.
- Reset, whether idle or mid-instruction, takes effect on the next edge:
  - state=IDLE.
  - All strobes=0; busy=0, halted=0, mem_error=0.
  - instr_count=0, wait counter=0, latched control bits=0.
- Outputs are Moore-decoded from state and the latched control bits. There are no combinational paths from dec_* inputs to outputs.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: ir_write=1 for exactly this cycle -> DECODE.
- DECODE:
  - Latch the dec_* bits into internal ctl_* bits; they stay constant for the rest of the instruction.
  - If dec_halt=1 -> HALT, with no retire and no pc_write. Otherwise -> EXECUTE.
- EXECUTE:
  - Sample alu_zero into ctl_take = ctl_uncond | (ctl_branch & alu_zero).
  - If ctl_mem_read or ctl_mem_write -> MEMORY (wait counter cleared).
  - Else if ctl_reg_write -> WRITEBACK.
  - Else retire: pc_write=1, pc_take=ctl_take, -> FETCH.
- MEMORY:
  - mem_read_en=ctl_mem_read and mem_write_en=ctl_mem_write are held every cycle until mem_ready=1.
  - If both ctl bits are set, read priority applies: only mem_read_en is driven.
  - On mem_ready=1:
    - If ctl_mem_read -> WRITEBACK.
    - Else retire (pc_write=1) -> FETCH.
  - If mem_ready=0 and the wait counter equals MEM_TIMEOUT-1: set mem_error=1 -> HALT, with no retire.
  - mem_ready is ignored in every state other than MEMORY.
- WRITEBACK: reg_write_en=1 and pc_write=1, pc_take=ctl_take -> FETCH.
- Retire:
  - Every cycle with pc_write=1 increments instr_count by 1, wrapping modulo 2^CNT_W.
  - At most one retire occurs per instruction.
- halt_req is evaluated only on a retire cycle. If halt_req=1 at that edge, the next state is IDLE instead of FETCH; the retire still counts.
- start while busy is ignored.
- HALT:
  - halted=1. Stay in HALT until reset.
  - start is ignored in HALT.
- Latency: ALU-only 3 cycles (FETCH, DECODE, EXECUTE). ALU+writeback 4. Store 4+w. Load 5+w. w = number of mem_ready=0 cycles in MEMORY.

Optional Feature:
SEQ_TRACE_EN
- Defined: on every retire, a simulation-only $display prints "RETIRE <instr_count+1> take=<pc_take>". Each entry into HALT prints "HALT err=<mem_error>".
- Undefined: no display statements; RTL is identical otherwise.

Test Plan:
- Reset, then start=1 for 1 cycle; decoder gives an ADD (reg_write=1, no mem/branch) -> ir_write in cycle 1, reg_write_en and pc_write in cycle 4 with pc_take=0, instr_count=1.
- LDUR (mem_read=1, reg_write=1); mem_ready low 2 cycles then high -> mem_read_en high 3 cycles, WRITEBACK next, retire at cycle 7, instr_count=1.
- CBZ (branch=1) with alu_zero=1 in EXECUTE -> pc_write=1, pc_take=1 in cycle 3. Repeat with alu_zero=0 -> pc_take=0.
- STUR with mem_ready held 0, MEM_TIMEOUT=15 -> mem_write_en high 15 cycles, then state=HALT, mem_error=1, halted=1, instr_count unchanged; start=1 has no effect.
- halt_req=1 raised in DECODE of the 2nd instruction -> that instruction retires, state=IDLE, busy=0, instr_count=2.
- reset=1 asserted during MEMORY -> next cycle state=IDLE, all strobes 0, instr_count=0, mem_error=0.
